pulse_stretch: RTL
==================

PULSE_STRETCH -- requirements
Module: pulse_stretch

Interface
REQ-001 The block SHALL have parameter PULSE_W, default 4, giving the number of cycles level is held high per accepted tick (legal range 1..255).
REQ-002 The block SHALL have parameter GAP_W, default 2, giving the minimum number of low cycles after each pulse before a new tick is accepted (legal range 0..255).
REQ-003 The block SHALL have parameter RETRIG, default 0, where 1 means a tick during HIGH restarts the pulse and 0 means it is dropped.
REQ-004 The block SHALL have parameter CNT_W, default 8, giving the width of drop_cnt.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all logic is clocked on the rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit, an asynchronous active-low reset.
REQ-007 The block SHALL have port tick, input, 1 bit, a single-cycle event request, synchronous to clk.
REQ-008 The block SHALL have port level, output, 1 bit, the registered stretched pulse.
REQ-009 The block SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.
REQ-010 The block SHALL have port drop, output, 1 bit, a registered one-cycle strobe flagging a tick that was ignored.
REQ-011 The block SHALL have port drop_cnt, output, CNT_W bits, a saturating count of ignored ticks.

Function
REQ-012 The block SHALL implement a three-state FSM with states IDLE, HIGH and GAP.
REQ-013 In IDLE with tick=1 sampled at edge k, the block SHALL enter HIGH and load the down-counter with PULSE_W-1.
REQ-014 After an accepted tick at edge k, level SHALL be 1 from edge k through edge k+PULSE_W, giving exactly PULSE_W cycles high; latency from tick to level is one cycle.
REQ-015 In HIGH, the counter SHALL decrement each cycle; when it reaches 0, the block SHALL go to GAP with the counter loaded to GAP_W-1, or to IDLE if GAP_W=0.
REQ-016 In GAP, level SHALL be 0, the counter SHALL decrement, and at 0 the block SHALL go to IDLE.
REQ-017 With RETRIG=1, a tick in HIGH (including the final HIGH cycle) SHALL reload the counter to PULSE_W-1, so level stays high for PULSE_W cycles after that tick with no low glitch.
REQ-018 With RETRIG=0, a tick in HIGH SHALL be ignored.
REQ-019 A tick in GAP SHALL always be ignored, regardless of RETRIG.
REQ-020 For every ignored tick, drop SHALL be 1 in the following cycle, and drop_cnt SHALL increment, saturating at 2^CNT_W-1 with no wrap.
REQ-021 A tick in IDLE, or a retriggering tick under REQ-017, SHALL NOT be counted as dropped.
REQ-022 With GAP_W=0, a tick in the cycle the FSM returns to IDLE SHALL be accepted, giving back-to-back pulses separated by exactly one low cycle.
REQ-023 Outputs level, busy and drop SHALL be driven directly from flops, with no combinational path from tick.

Reset
REQ-024 While reset=0, the block SHALL set state=IDLE, counter=0, level=0, busy=0, drop=0 and drop_cnt=0 asynchronously.
REQ-025 Reset asserted mid-pulse SHALL drop level to 0 immediately, without waiting for a clock edge.
REQ-026 A tick in the first cycle after reset deasserts SHALL be accepted normally.

Verification (PULSE_W=4, GAP_W=2, CNT_W=8 unless stated)
REQ-027 The bench SHALL cover a single tick at edge 10: level=1 over edges 10..14, busy=1 over edges 10..16, drop never asserted.
REQ-028 The bench SHALL cover RETRIG=0 with ticks at edges 10 and 12: one 4-cycle pulse, drop=1 after edge 12, drop_cnt=1.
REQ-029 The bench SHALL cover RETRIG=1 with ticks at edges 10 and 13: level high continuously over edges 10..17 (7 cycles), drop_cnt=0.
REQ-030 The bench SHALL cover a tick during GAP at edge 15 after a tick at edge 10: drop=1, drop_cnt=1, and a tick at edge 17 is accepted.
REQ-031 The bench SHALL cover CNT_W=2 with 5 dropped ticks: drop_cnt reads 1, 2, 3, 3, 3.
REQ-032 The bench SHALL cover reset asserted at edge 12 of a pulse started at edge 10: level=0 and busy=0 immediately, drop_cnt=0, and a tick after release gives a full 4-cycle pulse.

Source files
------------

// File: rtl/pulse_stretch.sv
// pulse_stretch: turns a single-cycle tick into a PULSE_W-cycle high level,
// followed by a GAP_W-cycle low guard interval during which ticks are refused.
//
// Parameters
//   PULSE_W  cycles level is held high per accepted tick (1..255)
//   GAP_W    low cycles after each pulse before a new tick is accepted (0..255)
//   RETRIG   1: tick while high restarts the pulse, 0: tick while high is dropped
//   CNT_W    width of drop_cnt
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   tick      single-cycle event request
//   level     registered stretched pulse
//   busy      registered, high whenever the FSM is not IDLE
//   drop      registered one-cycle strobe for an ignored tick
//   drop_cnt  saturating count of ignored ticks
module pulse_stretch #(
  parameter int PULSE_W = 4,
  parameter int GAP_W   = 2,
  parameter int RETRIG  = 0,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  output logic             level,
  output logic             busy,
  output logic             drop,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, GAP = 2'd2} state_t;

  localparam logic [7:0] PULSE_LD = 8'(PULSE_W - 1);
  // GAP_W=0 never enters GAP, so its load value is irrelevant there
  localparam logic [7:0] GAP_LD   = (GAP_W > 0) ? 8'(GAP_W - 1) : 8'd0;

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       level_nxt, busy_nxt, drop_nxt;

  // state / counter / output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      level    <= 1'b0;
      busy     <= 1'b0;
      drop     <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      level <= level_nxt;
      busy  <= busy_nxt;
      drop  <= drop_nxt;
      if (drop_nxt && (drop_cnt != {CNT_W{1'b1}}))
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // next-state / counter
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (tick) begin
          state_nxt = HIGH;
          cnt_nxt   = PULSE_LD;
        end
      end
      HIGH: begin
        if (tick && (RETRIG != 0)) begin
          // retrigger also applies on the last high cycle, so no low glitch
          cnt_nxt = PULSE_LD;
        end else if (cnt == 8'd0) begin
          if (GAP_W == 0) begin
            state_nxt = IDLE;
            cnt_nxt   = 8'd0;
          end else begin
            state_nxt = GAP;
            cnt_nxt   = GAP_LD;
          end
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      GAP: begin
        if (cnt == 8'd0) state_nxt = IDLE;
        else             cnt_nxt   = cnt - 8'd1;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  // outputs: computed from the next state and registered, so no tick->output path
  always_comb begin
    level_nxt = (state_nxt == HIGH);
    busy_nxt  = (state_nxt != IDLE);
    drop_nxt  = tick && (((state == HIGH) && (RETRIG == 0)) || (state == GAP));
  end

endmodule
